// File: rtl/updn_mod_counter_if.sv
// Control and status bundle for updn_mod_counter: range/mode/load/enable inputs
// plus count value, cascade strobes and sticky flags.
interface updn_mod_counter_if #(
   parameter int N = 8
);
   logic [N-1:0] lim;
   logic         sat;
   logic         load;
   logic [N-1:0] din;
   logic         eup;
   logic         edn;
   logic         clr_flags;
   logic [N-1:0] qout;
   logic         cout;
   logic         bout;
   logic         ovf;
   logic         unf;

   modport master (
      output lim, sat, load, din, eup, edn, clr_flags,
      input  qout, cout, bout, ovf, unf
   );

   modport slave (
      input  lim, sat, load, din, eup, edn, clr_flags,
      output qout, cout, bout, ovf, unf
   );
endinterface

// File: rtl/updn_mod_counter.sv
// Up/down modulo counter over 0..lim with wrap/saturate, clamped parallel load,
// combinational carry/borrow strobes for cascading, and sticky ovf/unf flags.
module updn_mod_counter #(
   parameter int N = 8
) (
   input  logic                clk,
   input  logic                reset,
   updn_mod_counter_if.slave   bus
);

   localparam logic [N-1:0] ZERO = '0;
   localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] q;
   logic [N-1:0] q_nxt;
   logic [N-1:0] load_val;
   logic         up;
   logic         dn;
   logic         at_top;
   logic         above;
   logic         at_zero;
   logic         ovf_q;
   logic         unf_q;

   assign up      = bus.eup & ~bus.edn & ~bus.load;
   assign dn      = bus.edn & ~bus.eup & ~bus.load;
   assign at_top  = (q >= bus.lim);
   assign above   = (q > bus.lim);
   assign at_zero = (q == ZERO);

   assign load_val = (bus.din > bus.lim) ? bus.lim : bus.din;

   always_comb begin
      q_nxt = q;
      if (bus.load) begin
         q_nxt = load_val;
      end else if (up) begin
         // Saturating at lim also pulls a value stranded above a lowered lim back in range.
         if (!at_top)      q_nxt = q + ONE;
         else if (bus.sat) q_nxt = bus.lim;
         else              q_nxt = ZERO;
      end else if (dn) begin
         if (above)        q_nxt = bus.lim;
         else if (at_zero) q_nxt = bus.sat ? ZERO : bus.lim;
         else              q_nxt = q - ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q     <= ZERO;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         q     <= q_nxt;
         ovf_q <= bus.cout ? 1'b1 : (bus.clr_flags ? 1'b0 : ovf_q);
         unf_q <= bus.bout ? 1'b1 : (bus.clr_flags ? 1'b0 : unf_q);
      end
   end

   assign bus.qout = q;
   assign bus.cout = up & at_top;
   assign bus.bout = dn & at_zero;
   assign bus.ovf  = ovf_q;
   assign bus.unf  = unf_q;

endmodule

// File: tb/tb_updn_mod_counter.sv
// Directed table-driven bench for updn_mod_counter at N=4.
module tb_updn_mod_counter;

   localparam int N = 4;

   logic clk;
   logic reset;

   updn_mod_counter_if #(.N(N)) bus ();

   updn_mod_counter #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         rst;
      logic [N-1:0] lim;
      logic         sat;
      logic         load;
      logic [N-1:0] din;
      logic         eup;
      logic         edn;
      logic         clr;
      logic         c;
      logic         b;
      logic [N-1:0] q;
      logic         ovf;
      logic         unf;
   } vec_t;

   vec_t vq[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic void add(input logic rst, input logic [N-1:0] lim, input logic sat,
                               input logic load, input logic [N-1:0] din, input logic eup,
                               input logic edn, input logic clr, input logic c, input logic b,
                               input logic [N-1:0] q, input logic ovf, input logic unf);
      vec_t v;
      v.rst = rst; v.lim = lim; v.sat = sat; v.load = load; v.din = din;
      v.eup = eup; v.edn = edn; v.clr = clr; v.c = c; v.b = b; v.q = q;
      v.ovf = ovf; v.unf = unf;
      vq.push_back(v);
   endfunction

   task automatic chk(input string name, input int idx, input logic [N-1:0] act,
                      input logic [N-1:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
      else
         n_pass++;
   endtask

   // Drive one vector between edges, check strobes before the edge, state after it.
   task automatic apply(input vec_t v, input int idx);
      reset         = v.rst;
      bus.lim       = v.lim;
      bus.sat       = v.sat;
      bus.load      = v.load;
      bus.din       = v.din;
      bus.eup       = v.eup;
      bus.edn       = v.edn;
      bus.clr_flags = v.clr;
      #1;
      chk("cout", idx, {3'b0, bus.cout}, {3'b0, v.c});
      chk("bout", idx, {3'b0, bus.bout}, {3'b0, v.b});
      @(posedge clk);
      #1;
      chk("qout", idx, bus.qout, v.q);
      chk("ovf",  idx, {3'b0, bus.ovf}, {3'b0, v.ovf});
      chk("unf",  idx, {3'b0, bus.unf}, {3'b0, v.unf});
   endtask

   initial begin
      //    rst lim sat ld din eu ed clr | c  b  q  ovf unf
      // reset, then wrap-up with lim=9
      add(1, 9, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      add(0, 9, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 0);
      add(0, 9, 0, 0, 0, 1, 0, 0,   0, 0, 2, 0, 0);
      add(0, 9, 0, 0, 0, 1, 0, 0,   0, 0, 3, 0, 0);
      add(0, 9, 0, 0, 0, 1, 0, 0,   0, 0, 4, 0, 0);
      add(0, 9, 0, 0, 0, 1, 0, 0,   0, 0, 5, 0, 0);
      add(0, 9, 0, 0, 0, 1, 0, 0,   0, 0, 6, 0, 0);
      add(0, 9, 0, 0, 0, 1, 0, 0,   0, 0, 7, 0, 0);
      add(0, 9, 0, 0, 0, 1, 0, 0,   0, 0, 8, 0, 0);
      add(0, 9, 0, 0, 0, 1, 0, 0,   0, 0, 9, 0, 0);
      add(0, 9, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 0);
      add(0, 9, 0, 0, 0, 1, 0, 0,   0, 0, 1, 1, 0);
      add(0, 9, 0, 0, 0, 1, 0, 0,   0, 0, 2, 1, 0);
      // reset clears ovf, then wrap-down from 0
      add(1, 9, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      add(0, 9, 0, 0, 0, 0, 1, 0,   0, 1, 9, 0, 1);
      add(0, 9, 0, 0, 0, 0, 1, 0,   0, 0, 8, 0, 1);
      add(0, 9, 0, 0, 0, 0, 1, 0,   0, 0, 7, 0, 1);
      // saturate, lim=5
      add(0, 5, 1, 1, 4, 0, 0, 0,   0, 0, 4, 0, 1);
      add(0, 5, 1, 0, 0, 1, 0, 0,   0, 0, 5, 0, 1);
      add(0, 5, 1, 0, 0, 1, 0, 0,   1, 0, 5, 1, 1);
      add(0, 5, 1, 0, 0, 1, 0, 0,   1, 0, 5, 1, 1);
      add(0, 5, 1, 0, 0, 1, 0, 0,   1, 0, 5, 1, 1);
      add(0, 5, 1, 0, 0, 0, 1, 0,   0, 0, 4, 1, 1);
      add(0, 5, 1, 0, 0, 0, 1, 0,   0, 0, 3, 1, 1);
      add(0, 5, 1, 0, 0, 0, 1, 0,   0, 0, 2, 1, 1);
      add(0, 5, 1, 0, 0, 0, 1, 0,   0, 0, 1, 1, 1);
      add(0, 5, 1, 0, 0, 0, 1, 0,   0, 0, 0, 1, 1);
      add(0, 5, 1, 0, 0, 0, 1, 0,   0, 1, 0, 1, 1);
      add(0, 5, 1, 0, 0, 0, 1, 0,   0, 1, 0, 1, 1);
      // load clamp and priority
      add(0, 9, 0, 1, 13, 1, 0, 0,  0, 0, 9, 1, 1);
      add(0, 9, 0, 1, 3, 0, 1, 0,   0, 0, 3, 1, 1);
      add(1, 9, 0, 1, 7, 1, 0, 0,   0, 0, 0, 0, 0);
      // simultaneous enables hold
      add(0, 9, 0, 1, 5, 0, 0, 0,   0, 0, 5, 0, 0);
      add(0, 9, 0, 0, 0, 1, 1, 0,   0, 0, 5, 0, 0);
      // lim lowered below qout
      add(0, 9, 0, 1, 8, 0, 0, 0,   0, 0, 8, 0, 0);
      add(0, 4, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 0);
      add(0, 9, 0, 1, 8, 0, 0, 0,   0, 0, 8, 1, 0);
      add(0, 4, 0, 0, 0, 0, 1, 0,   0, 0, 4, 1, 0);
      add(0, 9, 1, 1, 8, 0, 0, 0,   0, 0, 8, 1, 0);
      add(0, 4, 1, 0, 0, 1, 0, 0,   1, 0, 4, 1, 0);
      // flags: clear, set-wins-over-clear, reset
      add(0, 9, 0, 0, 0, 0, 0, 1,   0, 0, 4, 0, 0);
      add(0, 9, 0, 1, 9, 0, 0, 0,   0, 0, 9, 0, 0);
      add(0, 9, 0, 0, 0, 1, 0, 1,   1, 0, 0, 1, 0);
      add(0, 9, 0, 0, 0, 0, 1, 1,   0, 1, 9, 0, 1);
      add(0, 9, 0, 0, 0, 0, 0, 0,   0, 0, 9, 0, 1);
      add(1, 9, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

      foreach (vq[i]) apply(vq[i], i);

      // lim=0: every up cycle carries, every down cycle borrows, qout pinned at 0
      begin
         vec_t v;
         v = '{rst:0, lim:0, sat:0, load:0, din:0, eup:1, edn:0, clr:0,
               c:1, b:0, q:0, ovf:1, unf:0};
         for (int k = 0; k < 3; k++) apply(v, 100 + k);
         v.eup = 0; v.edn = 1; v.c = 0; v.b = 1; v.unf = 1;
         for (int k = 0; k < 3; k++) apply(v, 110 + k);
         v.sat = 1;
         apply(v, 120);
      end

      // long wrap-up run at lim=15 covers the full N-bit range
      begin
         vec_t v;
         apply('{rst:1, lim:15, sat:0, load:0, din:0, eup:0, edn:0, clr:0,
                 c:0, b:0, q:0, ovf:0, unf:0}, 200);
         for (int k = 0; k < 17; k++) begin
            v = '{rst:0, lim:15, sat:0, load:0, din:0, eup:1, edn:0, clr:0,
                  c:(k == 15), b:0, q:4'((k + 1) % 16), ovf:(k >= 15), unf:0};
            apply(v, 201 + k);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/updn_mod_counter.md
Name: updn_mod_counter

Overview:
Parametrised successor of the team's basic up/down binary counter. Counts up or down between 0 and a run-time programmable limit. Supports wrap or saturate mode, parallel load, per-cycle carry and borrow strobes, and sticky overflow/underflow flags. Intended for cascaded timers, programmable dividers and credit/occupancy trackers.

Parameters:
N, 8, counter width in bits (N >= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
lim  input  N  terminal count; counter range is 0..lim (modulus lim+1)
sat  input  1  0 = wrap at range ends, 1 = saturate at range ends
load  input  1  parallel load strobe
din  input  N  parallel load value
eup  input  1  count-up enable
edn  input  1  count-down enable
clr_flags  input  1  clears the sticky flags
qout  output  N  counter value (registered)
cout  output  1  carry strobe, combinational
bout  output  1  borrow strobe, combinational
ovf  output  1  sticky overflow flag (registered)
unf  output  1  sticky underflow flag (registered)

Behaviour:
- Reset: reset=1 at a rising edge forces qout=0, ovf=0, unf=0. Reset overrides every other input.
- Priority for qout is reset > load > count > hold.
- Load: qout <= (din > lim) ? lim : din. The load value is clamped to the range. Count enables are ignored in a load cycle. cout and bout are 0 in a load cycle.
- Direction decode: up = eup & ~edn & ~load; dn = edn & ~eup & ~load. eup=edn=1 means hold, and cout=bout=0.
- Up, when qout < lim: qout <= qout+1.
- Up, when qout >= lim:
  - sat=0: qout <= 0.
  - sat=1: qout holds at lim. If qout > lim (lim lowered mid-count), qout <= lim.
- Down, when 0 < qout <= lim: qout <= qout-1.
- Down, when qout > lim: qout <= lim. This is a clamp and is not a borrow.
- Down, when qout == 0:
  - sat=0: qout <= lim.
  - sat=1: qout holds at 0.
- cout = up & (qout >= lim). It is asserted in both modes, so in sat mode it marks an attempted overflow. It is a same-cycle combinational strobe, intended to drive eup of the next cascaded stage.
- bout = dn & (qout == 0). It follows the same rules as cout.
- lim = 0:
  - Up: qout stays 0 and cout=1 on every up cycle.
  - Down: qout stays 0 and bout=1 on every down cycle.
- Sticky flags:
  - ovf <= cout ? 1 : (clr_flags ? 0 : ovf).
  - unf <= bout ? 1 : (clr_flags ? 0 : unf).
  - A set on the same cycle as clr_flags wins.
  - load does not affect the flags.
- All arithmetic is N-bit unsigned. Comparisons are unsigned. No intermediate value exceeds N bits.
- sat and lim are sampled every cycle. Changing them mid-count takes effect on the next edge, following the rules above.

Test Plan:
- Reset and wrap-up (N=4, lim=9, sat=0): reset, then eup=1 for 12 cycles -> qout 0,1..9,0,1. cout=1 only in the cycle with qout=9. ovf=1 after that edge.
- Wrap-down and borrow (lim=9, sat=0, start at 0): edn=1 for 3 cycles -> qout 9,8,7. bout=1 in the first cycle only. unf set.
- Saturate (lim=5, sat=1): load din=4, then eup for 4 cycles -> qout 4,5,5,5. cout=1 in the last three cycles. Then edn for 7 cycles -> qout 4,3,2,1,0,0,0 and bout=1 twice.
- Load clamp and priority (lim=9): load=1 with din=13 and eup=1 -> qout=9, cout=0. Load with din=3 -> qout=3. reset=1 with load=1 -> qout=0.
- Simultaneous and mid-operation changes:
  - eup=edn=1 -> qout unchanged, cout=bout=0.
  - qout=8, then lim changed to 4: up -> qout=0 in wrap mode and cout=1; down -> qout=4 with bout=0.
- Flags: ovf=1, then clr_flags=1 in a cycle without cout -> ovf=0 next cycle. clr_flags=1 in the same cycle as cout=1 -> ovf stays 1. Reset clears both flags.
